imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Byte-stream program loader that fills the instruction memory of the pipelined RV32I core before execution and holds the core in reset until a complete, checksum-verified image has been written. It receives framed bytes over a valid/ready link, assembles little-endian 32-bit instruction words and issues one write per word to the instruction-memory write port. It drives the core's reset, and testbenches use it to place programs in memory instead of relying on preloaded images.

## Interface
- ADDR_W, 10, instruction-memory word-address width; capacity DEPTH = 2**ADDR_W words
- SYNC_BYTE, 8'hA5, frame start marker
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high; clk is the only clock and reset is asynchronous active-high
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte; transfer when rx_valid && rx_ready at a rising edge
- reload  in  1  single-cycle pulse; re-arms the loader from DONE or ERROR
- imem_we  out  1  instruction-memory write enable, one-cycle pulse per word
- imem_addr  out  ADDR_W  word address of the write
- imem_wdata  out  32  instruction word
- core_reset  out  1  reset to the processor; high while loading
- load_done  out  1  image loaded and verified
- load_error  out  1  frame rejected
- words_loaded  out  ADDR_W+1  count of words written in the current frame

## Operation
- Frame: SYNC_BYTE, LEN_LO, LEN_HI (N = word count, 16-bit), 4N data bytes (each word LSB first), CSUM = sum of all 4N data bytes mod 256.
- States: SYNC, LEN0, LEN1, DATA, CSUM, DONE, ERROR.
- SYNC: bytes other than SYNC_BYTE are accepted and discarded; SYNC_BYTE -> LEN0.
- LEN0 latches the low byte, then LEN1 latches the high byte. In LEN1, N > DEPTH -> ERROR. N == 0 -> CSUM, with expected CSUM 0x00. Otherwise -> DATA.
- DATA: the byte counter (0..3) shifts bytes into the word register. On the 4th byte, the word is registered for writing, words_loaded increments and the running sum updates. After word N -> CSUM.
- CSUM: byte == running sum -> DONE. Otherwise -> ERROR.
- DONE: rx_ready=0, load_done=1, core_reset=0.
- ERROR: rx_ready=1 and all bytes are discarded. load_error=1 and core_reset stays 1.
- reload in DONE or ERROR -> SYNC:
  - core_reset=1, load_done=0, load_error=0.
  - words_loaded, the running sum and the byte counter clear.
  - Memory contents are not touched.
- reload in any other state is ignored.
- Addresses start at 0 for every frame and increment by 1 per word. The address cannot wrap because N ≤ DEPTH is enforced.
- The running sum is an 8-bit accumulator that wraps modulo 256.

## Timing
- Reset values: state=SYNC, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, load_done=0, load_error=0, words_loaded=0.
- Reset is asynchronous and may occur mid-frame. The loader immediately returns to reset values. The partial frame is abandoned, and words already written remain in memory.
- rx_ready is combinational from state only: 1 in SYNC, LEN0, LEN1, DATA, CSUM and ERROR, 0 in DONE. It never depends on rx_valid.
- Full throughput: one byte per cycle, so a word completes every 4 cycles at most.
- imem_we is registered. It is high for exactly one cycle, the cycle after the 4th byte of a word is accepted, with imem_addr and imem_wdata valid in that same cycle. imem_addr and imem_wdata hold their values after the pulse.
- words_loaded updates in the same cycle that imem_we is high.
- load_done=1 and core_reset=0 in the cycle after the matching CSUM byte is accepted.
- load_error=1 in the cycle after the offending LEN_HI or CSUM byte is accepted.
- reload takes effect at the next edge: the following cycle shows SYNC and core_reset=1.
- If reload and a valid byte coincide in DONE, rx_ready=0, so the byte is not accepted.
- If reload and a valid byte coincide in ERROR, the byte is consumed as a discard; it is not treated as SYNC.
- End-to-end latency: the last CSUM byte at edge k gives core_reset low from edge k+1.

## Test plan
- Stream A5 02 00 93 00 50 00 13 01 A0 00 97, back-to-back. Required:
  - imem_we pulses at addr 0 with wdata 0x00500093, then at addr 1 with 0x00A00113.
  - words_loaded=2, load_done=1 and core_reset=0 one cycle after 0x97.
- Same frame with CSUM 0x98 -> load_error=1, core_reset=1, load_done=0. Then reload plus the correct frame -> load_done=1.
- Leading garbage 00 FF 5A before A5 02 00 ... 97 -> the garbage is ignored and the result is identical to the first scenario.
- ADDR_W=2, frame A5 05 00 -> load_error right after LEN_HI, with no imem_we pulses.
- Zero-length frame A5 00 00 00 -> load_done=1, words_loaded=0, no writes.
- Assert reset after the 6th byte of the first scenario's frame -> all outputs return to reset values immediately. The full frame then loads correctly.
- rx_valid toggling every other cycle -> same writes and the same final state as back-to-back delivery.

Source files
------------

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader
// Description : Byte-stream program loader for the RV32I core. Receives a
//               framed image over a valid/ready byte link, assembles
//               little-endian 32-bit words, writes them to instruction
//               memory and releases the core from reset once the whole
//               image has been written and its checksum verified.
//
//               Frame: SYNC_BYTE, LEN_LO, LEN_HI, 4*N data bytes, CSUM
//               where CSUM = sum of all data bytes mod 256.
//
// Ports       : clk, reset          - clock, async active-high reset
//               rx_data/valid/ready - incoming byte stream
//               reload              - re-arm pulse from DONE or ERROR
//               imem_we/addr/wdata  - instruction-memory write port
//               core_reset          - processor reset, high until loaded
//               load_done/error     - frame verdict
//               words_loaded        - words written in the current frame
// Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    // Length field is 16 bits; compare it against capacity in 17 bits so
    // that DEPTH = 65536 (ADDR_W = 16) is still representable.
    localparam logic [16:0]     c_depth  = 17'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] c_wl_one = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        S_SYNC  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [7:0]         r_len_lo;
    logic [15:0]        r_len;
    logic [1:0]         r_byte_cnt;
    logic [31:0]        r_word;
    logic [7:0]         r_sum;
    logic               r_imem_we;
    logic [ADDR_W-1:0]  r_imem_addr;
    logic [31:0]        r_imem_wdata;
    logic [ADDR_W:0]    r_words_loaded;

    logic               w_accept;
    logic               w_rearm;
    logic [15:0]        w_len_full;
    logic [ADDR_W:0]    w_wl_next;
    logic               w_last_word;
    logic [31:0]        w_word_full;

    assign w_accept    = rx_valid && rx_ready;
    assign w_rearm     = reload && ((r_state == S_DONE) || (r_state == S_ERROR));
    assign w_len_full  = {rx_data, r_len_lo};
    assign w_wl_next   = r_words_loaded + c_wl_one;
    assign w_last_word = (17'(w_wl_next) == {1'b0, r_len});
    // Bytes arrive LSB first, so each new byte enters at the top and the
    // oldest one ends up in bits [7:0] after four shifts.
    assign w_word_full = {rx_data, r_word[31:8]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_SYNC: begin
                if (w_accept && (rx_data == SYNC_BYTE)) begin
                    w_state_nxt = S_LEN0;
                end
            end
            S_LEN0: begin
                if (w_accept) begin
                    w_state_nxt = S_LEN1;
                end
            end
            S_LEN1: begin
                if (w_accept) begin
                    if ({1'b0, w_len_full} > c_depth) begin
                        w_state_nxt = S_ERROR;
                    end else if (w_len_full == 16'd0) begin
                        w_state_nxt = S_CSUM;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept && (r_byte_cnt == 2'd3) && w_last_word) begin
                    w_state_nxt = S_CSUM;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_state_nxt = (rx_data == r_sum) ? S_DONE : S_ERROR;
                end
            end
            S_DONE: begin
                if (reload) begin
                    w_state_nxt = S_SYNC;
                end
            end
            S_ERROR: begin
                // A byte coinciding with reload is simply discarded.
                if (reload) begin
                    w_state_nxt = S_SYNC;
                end
            end
            default: begin
                w_state_nxt = S_SYNC;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: length, word assembly, checksum, memory write
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len_lo       <= 8'd0;
            r_len          <= 16'd0;
            r_byte_cnt     <= 2'd0;
            r_word         <= 32'd0;
            r_sum          <= 8'd0;
            r_imem_we      <= 1'b0;
            r_imem_addr    <= '0;
            r_imem_wdata   <= 32'd0;
            r_words_loaded <= '0;
        end else begin
            r_imem_we <= 1'b0;
            if (w_rearm) begin
                r_words_loaded <= '0;
                r_sum          <= 8'd0;
                r_byte_cnt     <= 2'd0;
            end else if (w_accept) begin
                case (r_state)
                    S_SYNC: begin
                        if (rx_data == SYNC_BYTE) begin
                            r_words_loaded <= '0;
                            r_sum          <= 8'd0;
                            r_byte_cnt     <= 2'd0;
                        end
                    end
                    S_LEN0: begin
                        r_len_lo <= rx_data;
                    end
                    S_LEN1: begin
                        r_len <= w_len_full;
                    end
                    S_DATA: begin
                        r_sum      <= r_sum + rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_word     <= w_word_full;
                        if (r_byte_cnt == 2'd3) begin
                            r_imem_we      <= 1'b1;
                            r_imem_addr    <= r_words_loaded[ADDR_W-1:0];
                            r_imem_wdata   <= w_word_full;
                            r_words_loaded <= w_wl_next;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rx_ready     = (r_state != S_DONE);
    assign core_reset   = (r_state != S_DONE);
    assign load_done    = (r_state == S_DONE);
    assign load_error   = (r_state == S_ERROR);
    assign imem_we      = r_imem_we;
    assign imem_addr    = r_imem_addr;
    assign imem_wdata   = r_imem_wdata;
    assign words_loaded = r_words_loaded;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_boot_loader
// Description : Directed self-checking bench for imem_boot_loader. A main
//               instance (ADDR_W=10) runs the frame scenarios; a small
//               instance (ADDR_W=2) exercises the over-length rejection.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        s_rx_valid;
    logic        reload;

    logic        rx_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        load_done;
    logic        load_error;
    logic [10:0] words_loaded;

    logic        s_rx_ready;
    logic        s_imem_we;
    logic [1:0]  s_imem_addr;
    logic [31:0] s_imem_wdata;
    logic        s_core_reset;
    logic        s_load_done;
    logic        s_load_error;
    logic [2:0]  s_words_loaded;

    int total;
    int bad;
    int s_writes;

    logic [31:0] wa[$];
    logic [31:0] wd[$];

    imem_boot_loader #(.ADDR_W(10), .SYNC_BYTE(8'hA5)) u_dut (
        .clk          (clk),
        .reset        (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .reload       (reload),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset   (core_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    imem_boot_loader #(.ADDR_W(2), .SYNC_BYTE(8'hA5)) u_small (
        .clk          (clk),
        .reset        (rst),
        .rx_data      (rx_data),
        .rx_valid     (s_rx_valid),
        .rx_ready     (s_rx_ready),
        .reload       (reload),
        .imem_we      (s_imem_we),
        .imem_addr    (s_imem_addr),
        .imem_wdata   (s_imem_wdata),
        .core_reset   (s_core_reset),
        .load_done    (s_load_done),
        .load_error   (s_load_error),
        .words_loaded (s_words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write pulse, sampled on the falling edge.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wa.push_back(32'(imem_addr));
            wd.push_back(imem_wdata);
        end
        if (s_imem_we === 1'b1) begin
            s_writes <= s_writes + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one byte for exactly one rising edge (inputs change #1 after
    // the edge). gap inserts an idle cycle afterwards.
    task automatic send(input logic [7:0] b, input bit gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_small(input logic [7:0] b);
        rx_data    = b;
        s_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        s_rx_valid = 1'b0;
    endtask

    task automatic send_frame_a(input logic [7:0] csum, input bit gap);
        logic [7:0] fr [11];
        fr = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
               8'h13, 8'h01, 8'hA0, 8'h00};
        for (int i = 0; i < 11; i++) send(fr[i], gap);
        send(csum, gap);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic check_frame_a(input string tag);
        @(negedge clk);
        chk({tag, "_done"},     32'(load_done),    32'd1);
        chk({tag, "_corerst"},  32'(core_reset),   32'd0);
        chk({tag, "_err"},      32'(load_error),   32'd0);
        chk({tag, "_wl"},       32'(words_loaded), 32'd2);
        chk({tag, "_rdy"},      32'(rx_ready),     32'd0);
        chk({tag, "_nwr"},      32'(wa.size()),    32'd2);
        if (wa.size() == 2) begin
            chk({tag, "_a0"}, wa[0], 32'd0);
            chk({tag, "_d0"}, wd[0], 32'h00500093);
            chk({tag, "_a1"}, wa[1], 32'd1);
            chk({tag, "_d1"}, wd[1], 32'h00A00113);
        end
        chk({tag, "_hold_a"},   32'(imem_addr),    32'd1);
        chk({tag, "_hold_d"},   imem_wdata,        32'h00A00113);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        s_writes   = 0;
        rst        = 1'b1;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        s_rx_valid = 1'b0;
        reload     = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy",     32'(rx_ready),     32'd1);
        chk("rst_we",      32'(imem_we),      32'd0);
        chk("rst_addr",    32'(imem_addr),    32'd0);
        chk("rst_wdata",   imem_wdata,        32'd0);
        chk("rst_corerst", 32'(core_reset),   32'd1);
        chk("rst_done",    32'(load_done),    32'd0);
        chk("rst_err",     32'(load_error),   32'd0);
        chk("rst_wl",      32'(words_loaded), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Scenario 1: back-to-back good frame
        wa.delete(); wd.delete();
        send_frame_a(8'h97, 1'b0);
        check_frame_a("s1");

        // Reload from DONE
        pulse_reload();
        @(negedge clk);
        chk("rl_corerst", 32'(core_reset),   32'd1);
        chk("rl_done",    32'(load_done),    32'd0);
        chk("rl_wl",      32'(words_loaded), 32'd0);
        chk("rl_rdy",     32'(rx_ready),     32'd1);

        // Scenario 2: bad checksum, then reload and good frame
        wa.delete(); wd.delete();
        send_frame_a(8'h98, 1'b0);
        @(negedge clk);
        chk("s2_err",     32'(load_error), 32'd1);
        chk("s2_corerst", 32'(core_reset), 32'd1);
        chk("s2_done",    32'(load_done),  32'd0);
        chk("s2_rdy",     32'(rx_ready),   32'd1);
        // Bytes in ERROR, including A5, are discarded
        send(8'hA5, 1'b0);
        @(negedge clk);
        chk("s2_stay_err", 32'(load_error), 32'd1);
        pulse_reload();
        @(negedge clk);
        chk("s2_rl_err", 32'(load_error), 32'd0);
        wa.delete(); wd.delete();
        send_frame_a(8'h97, 1'b0);
        check_frame_a("s2b");

        // Scenario 3: leading garbage
        pulse_reload();
        wa.delete(); wd.delete();
        send(8'h00, 1'b0);
        send(8'hFF, 1'b0);
        send(8'h5A, 1'b0);
        send_frame_a(8'h97, 1'b0);
        check_frame_a("s3");

        // Scenario 4: small instance, N=5 exceeds DEPTH=4
        send_small(8'hA5);
        send_small(8'h05);
        send_small(8'h00);
        @(negedge clk);
        chk("s4_err",     32'(s_load_error),   32'd1);
        chk("s4_corerst", 32'(s_core_reset),   32'd1);
        chk("s4_done",    32'(s_load_done),    32'd0);
        chk("s4_rdy",     32'(s_rx_ready),     32'd1);
        chk("s4_wl",      32'(s_words_loaded), 32'd0);
        repeat (3) @(negedge clk);
        chk("s4_nwr",     32'(s_writes),       32'd0);

        // Scenario 5: zero-length frame
        pulse_reload();
        wa.delete(); wd.delete();
        send(8'hA5, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        @(negedge clk);
        chk("s5_done",    32'(load_done),    32'd1);
        chk("s5_corerst", 32'(core_reset),   32'd0);
        chk("s5_wl",      32'(words_loaded), 32'd0);
        chk("s5_nwr",     32'(wa.size()),    32'd0);

        // Scenario 6: asynchronous reset after the 6th byte
        pulse_reload();
        send(8'hA5, 1'b0);
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        send(8'h93, 1'b0);
        send(8'h00, 1'b0);
        send(8'h50, 1'b0);
        rst = 1'b1;
        #1;
        chk("s6_rdy",     32'(rx_ready),     32'd1);
        chk("s6_we",      32'(imem_we),      32'd0);
        chk("s6_addr",    32'(imem_addr),    32'd0);
        chk("s6_wdata",   imem_wdata,        32'd0);
        chk("s6_corerst", 32'(core_reset),   32'd1);
        chk("s6_done",    32'(load_done),    32'd0);
        chk("s6_err",     32'(load_error),   32'd0);
        chk("s6_wl",      32'(words_loaded), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wa.delete(); wd.delete();
        send_frame_a(8'h97, 1'b0);
        check_frame_a("s6");

        // Scenario 7: rx_valid toggling every other cycle
        pulse_reload();
        wa.delete(); wd.delete();
        send_frame_a(8'h97, 1'b1);
        check_frame_a("s7");

        // Reload outside DONE/ERROR is ignored
        pulse_reload();
        send(8'hA5, 1'b0);
        pulse_reload();
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        @(negedge clk);
        chk("rl_ignored", 32'(load_done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
